// File: rtl/sd_modulator_pkg.sv
// Shared constants and types for the sigma-delta modulator.
//   FS            full-scale feedback magnitude (2^15)
//   I1_W / I2_W   integrator widths, I2_SUM_W is the pre-saturation sum width
//   I2_MAX/I2_MIN symmetric saturation limits of the second integrator
//   MODE_*        output encodings, state_t the control FSM states
package sd_pkg;
  localparam int FS        = 32768;
  localparam int I1_W      = 18;
  localparam int I2_W      = 22;
  localparam int I2_SUM_W  = I2_W + 2;

  localparam logic signed [I1_W-1:0] FB_POS = I1_W'(FS);
  localparam logic signed [I1_W-1:0] FB_NEG = I1_W'(-FS);
  localparam logic signed [I2_W-1:0] I2_MAX = 22'sd2097151;
  localparam logic signed [I2_W-1:0] I2_MIN = -22'sd2097151;

  localparam logic MODE_NRZ   = 1'b0;
  localparam logic MODE_MANCH = 1'b1;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/sd_modulator_if.sv
// Sample delivery handshake (one-entry buffered valid/ready).
//   sample_data   signed input sample
//   sample_valid  producer offers sample_data
//   sample_ready  modulator buffer is empty
interface sd_modulator_if #(parameter int IN_W = 16);
  logic signed [IN_W-1:0] sample_data;
  logic                   sample_valid;
  logic                   sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/sd_modulator_core.sv
// Modulator loop: integrators, feedback, saturation and output bit.
//   SYSCLK/SYSRST  clock, synchronous active-high reset
//   step           run one modulator step this cycle
//   clear          zero integrators and feedback (wins over step)
//   order          0 = first-order, 1 = second-order loop
//   x              sample used by this step
//   y_next         output bit after this cycle's update (held when no step)
module sd_mod_core
  import sd_pkg::*;
#(
  parameter int IN_W = 16
) (
  input  logic                   SYSCLK,
  input  logic                   SYSRST,
  input  logic                   step,
  input  logic                   clear,
  input  logic                   order,
  input  logic signed [IN_W-1:0] x,
  output logic                   y_next
);
  logic signed [I1_W-1:0]     i1_q, i1_d, i1_sum;
  logic signed [I2_W-1:0]     i2_q, i2_d, i2_sat;
  logic signed [I2_SUM_W-1:0] i2_sum;
  logic signed [I1_W-1:0]     fb_q, fb_d;
  logic                       y_q, y_d, y_step;

  function automatic logic signed [I2_W-1:0] sat_i2(input logic signed [I2_SUM_W-1:0] v);
    if (v > I2_SUM_W'(I2_MAX))      return I2_MAX;
    else if (v < I2_SUM_W'(I2_MIN)) return I2_MIN;
    else                            return I2_W'(v);
  endfunction

  always_comb begin
    i1_d   = i1_q;
    i2_d   = i2_q;
    fb_d   = fb_q;
    y_d    = y_q;
    // i2 integrates the freshly updated i1, both referenced to the old fb
    i1_sum = i1_q + I1_W'(x) - fb_q;
    i2_sum = I2_SUM_W'(i2_q) + I2_SUM_W'(i1_sum) - I2_SUM_W'(fb_q);
    i2_sat = sat_i2(i2_sum);
    y_step = order ? ~i2_sat[I2_W-1] : ~i1_sum[I1_W-1];
    if (clear) begin
      i1_d = '0;
      i2_d = '0;
      fb_d = '0;
      y_d  = 1'b0;
    end else if (step) begin
      i1_d = i1_sum;
      if (order) i2_d = i2_sat;
      fb_d = y_step ? FB_POS : FB_NEG;
      y_d  = y_step;
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      i1_q <= '0;
      i2_q <= '0;
      fb_q <= '0;
      y_q  <= 1'b0;
    end else begin
      i1_q <= i1_d;
      i2_q <= i2_d;
      fb_q <= fb_d;
      y_q  <= y_d;
    end
  end

  assign y_next = y_d;
endmodule

// File: rtl/sd_modulator.sv
// Digital sigma-delta modulator: 16-bit signed samples in, 1-bit bitstream out.
//   SYSCLK/SYSRST  clock, synchronous active-high reset
//   en             run enable; mode/order/clkdiv/osr latched when a run starts
//   smp            sample handshake (slave side), one-entry buffer
//   underrun       one-cycle pulse when a sample boundary finds no sample
//   DSDOUT         NRZ data (mode 0) or Manchester data (mode 1)
//   SDCLKOUT       bit clock in mode 0, 0 in mode 1
module sd_modulator
  import sd_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int DIV_W = 8,
  parameter int OSR_W = 8
) (
  input  logic             SYSCLK,
  input  logic             SYSRST,
  input  logic             en,
  input  logic             mode,
  input  logic             order,
  input  logic [DIV_W-1:0] clkdiv,
  input  logic [OSR_W-1:0] osr,
  sd_modulator_if.slave    smp,
  output logic             underrun,
  output logic             DSDOUT,
  output logic             SDCLKOUT
);
  state_t                 state_q, state_d;
  logic                   buf_full_q, buf_full_d;
  logic signed [IN_W-1:0] buf_q, buf_d, x_q, x_d, x_step, next_smp;
  logic [DIV_W-1:0]       cnt_q, cnt_d, clkdiv_q, clkdiv_d;
  logic [OSR_W-1:0]       bcnt_q, bcnt_d, osr_q, osr_d;
  logic                   phase_q, phase_d, mode_q, mode_d, order_q, order_d;
  logic                   dsdout_q, dsdout_d, sdclk_q, sdclk_d, underrun_q, underrun_d;
  logic                   step, clear, core_order, mode_eff, y_next;
  logic                   avail, take_buf, take_bypass;

  assign smp.sample_ready = ~buf_full_q;
  assign avail            = buf_full_q | smp.sample_valid;
  assign next_smp         = buf_full_q ? buf_q : smp.sample_data;

  sd_mod_core #(.IN_W(IN_W)) u_core (
    .SYSCLK (SYSCLK),
    .SYSRST (SYSRST),
    .step   (step),
    .clear  (clear),
    .order  (core_order),
    .x      (x_step),
    .y_next (y_next)
  );

  always_comb begin
    state_d     = state_q;
    buf_full_d  = buf_full_q;
    buf_d       = buf_q;
    x_d         = x_q;
    cnt_d       = cnt_q;
    bcnt_d      = bcnt_q;
    phase_d     = phase_q;
    mode_d      = mode_q;
    order_d     = order_q;
    clkdiv_d    = clkdiv_q;
    osr_d       = osr_q;
    underrun_d  = 1'b0;
    step        = 1'b0;
    clear       = 1'b0;
    take_buf    = 1'b0;
    take_bypass = 1'b0;
    x_step      = x_q;
    core_order  = order_q;
    mode_eff    = mode_q;

    case (state_q)
      IDLE: begin
        clear = 1'b1;
        if (en && avail) begin
          // start: first modulator step runs with the freshly latched config
          clear       = 1'b0;
          step        = 1'b1;
          mode_d      = mode;
          order_d     = order;
          clkdiv_d    = clkdiv;
          osr_d       = osr;
          core_order  = order;
          mode_eff    = mode;
          take_buf    = buf_full_q;
          take_bypass = ~buf_full_q;
          x_d         = next_smp;
          x_step      = next_smp;
          cnt_d       = '0;
          phase_d     = 1'b0;
          bcnt_d      = '0;
          state_d     = RUN;
        end
      end
      RUN: begin
        if (!en) begin
          state_d = IDLE;
          clear   = 1'b1;
        end else begin
          if (cnt_q == clkdiv_q) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
          // bit tick: end of the high half of the bit clock
          if (phase_q && (cnt_q == clkdiv_q)) begin
            step = 1'b1;
            if (bcnt_q == osr_q) begin
              bcnt_d = '0;
              if (avail) begin
                take_buf    = buf_full_q;
                take_bypass = ~buf_full_q;
                x_d         = next_smp;
                x_step      = next_smp;
              end else begin
                underrun_d = 1'b1;
              end
            end else begin
              bcnt_d = bcnt_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // a bypassed sample goes straight to x and must not also fill the buffer
    if (take_buf) buf_full_d = 1'b0;
    if (smp.sample_valid && !buf_full_q && !take_bypass) begin
      buf_full_d = 1'b1;
      buf_d      = smp.sample_data;
    end

    dsdout_d = 1'b0;
    sdclk_d  = 1'b0;
    if (state_d == RUN) begin
      if (mode_eff == MODE_NRZ) begin
        dsdout_d = y_next;
        sdclk_d  = phase_d;
      end else begin
        dsdout_d = phase_d ? y_next : ~y_next;
      end
    end
  end

  always_ff @(posedge SYSCLK) begin
    if (SYSRST) begin
      state_q    <= IDLE;
      buf_full_q <= 1'b0;
      buf_q      <= '0;
      x_q        <= '0;
      cnt_q      <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b0;
      mode_q     <= MODE_NRZ;
      order_q    <= 1'b0;
      clkdiv_q   <= '0;
      osr_q      <= '0;
      dsdout_q   <= 1'b0;
      sdclk_q    <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_full_q <= buf_full_d;
      buf_q      <= buf_d;
      x_q        <= x_d;
      cnt_q      <= cnt_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      mode_q     <= mode_d;
      order_q    <= order_d;
      clkdiv_q   <= clkdiv_d;
      osr_q      <= osr_d;
      dsdout_q   <= dsdout_d;
      sdclk_q    <= sdclk_d;
      underrun_q <= underrun_d;
    end
  end

  assign DSDOUT   = dsdout_q;
  assign SDCLKOUT = sdclk_q;
  assign underrun = underrun_q;
endmodule

// File: tb/tb_sd_modulator.sv
// Self-checking bench for sd_modulator: table of waveform vectors plus
// hand-written sequences for reset, underrun/bypass, buffering and enable.
module tb_sd_modulator;
  import sd_pkg::*;

  logic       SYSCLK = 1'b0;
  logic       SYSRST;
  logic       en, mode, order;
  logic [7:0] clkdiv, osr;
  logic       underrun, DSDOUT, SDCLKOUT;

  sd_modulator_if #(.IN_W(16)) smp ();

  sd_modulator #(.IN_W(16), .DIV_W(8), .OSR_W(8)) dut (
    .SYSCLK   (SYSCLK),
    .SYSRST   (SYSRST),
    .en       (en),
    .mode     (mode),
    .order    (order),
    .clkdiv   (clkdiv),
    .osr      (osr),
    .smp      (smp),
    .underrun (underrun),
    .DSDOUT   (DSDOUT),
    .SDCLKOUT (SDCLKOUT)
  );

  always #5 SYSCLK = ~SYSCLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge SYSCLK);
    #1;
  endtask

  task automatic do_reset();
    SYSRST = 1'b1;
    en = 1'b0;
    smp.sample_valid = 1'b0;
    smp.sample_data = '0;
    tick();
    tick();
    SYSRST = 1'b0;
  endtask

  // Reset, configure, offer x and enable; returns just after the start edge (c=0).
  task automatic start(input logic m, input logic o, input logic [7:0] cd,
                       input logic [7:0] os, input logic signed [15:0] xv);
    do_reset();
    mode = m; order = o; clkdiv = cd; osr = os;
    smp.sample_data = xv;
    smp.sample_valid = 1'b1;
    en = 1'b1;
    tick();
  endtask

  typedef struct {
    logic               mode;
    logic               order;
    logic [7:0]         clkdiv;
    logic [7:0]         osr;
    logic signed [15:0] x;
    logic [31:0]        exp_dsd;
    logic [31:0]        exp_clk;
  } vec_t;

  localparam int NV = 7;
  vec_t vecs[NV];

  initial begin
    logic [31:0] dsd_cap, clk_cap;
    logic        ur;
    int          ones, i2v, i2max;
    logic [0:25] ur_seq, dsd_seq;
    logic [0:19] rdy_b, dsd_b;
    logic [3:0]  dsd4;
    logic        rdy0;

    // waveforms of the first 32 cycles after the start edge, MSB = first cycle
    vecs[0] = '{1'b0, 1'b0, 8'd1, 8'd15, 16'sd0,      32'hF0F0F0F0, 32'h33333333};
    vecs[1] = '{1'b1, 1'b0, 8'd3, 8'd15, 16'sd0,      32'h0FF00FF0, 32'h00000000};
    vecs[2] = '{1'b0, 1'b0, 8'd0, 8'd7,  16'sd16384,  32'hF3F3F3F3, 32'h55555555};
    vecs[3] = '{1'b0, 1'b1, 8'd0, 8'd3,  16'sd0,      32'hC3C3C3C3, 32'h55555555};
    vecs[4] = '{1'b1, 1'b0, 8'd0, 8'd7,  16'sd16384,  32'h59595959, 32'h00000000};
    vecs[5] = '{1'b0, 1'b0, 8'd0, 8'd7,  16'sh8000,   32'h00000000, 32'h55555555};
    vecs[6] = '{1'b0, 1'b0, 8'd0, 8'd7,  16'sd32767,  32'hFFFFFFFF, 32'h55555555};

    mode = 1'b0; order = 1'b0; clkdiv = '0; osr = '0;
    do_reset();
    check("reset_dsdout",   64'(DSDOUT), 64'd0);
    check("reset_sdclkout", 64'(SDCLKOUT), 64'd0);
    check("reset_ready",    64'(smp.sample_ready), 64'd1);
    check("reset_underrun", 64'(underrun), 64'd0);

    for (int v = 0; v < NV; v++) begin
      start(vecs[v].mode, vecs[v].order, vecs[v].clkdiv, vecs[v].osr, vecs[v].x);
      dsd_cap = '0; clk_cap = '0; ur = 1'b0;
      for (int c = 0; c < 32; c++) begin
        dsd_cap[31-c] = DSDOUT;
        clk_cap[31-c] = SDCLKOUT;
        ur = ur | underrun;
        tick();
      end
      check($sformatf("vec%0d_dsdout", v),   64'(dsd_cap), 64'(vecs[v].exp_dsd));
      check($sformatf("vec%0d_sdclkout", v), 64'(clk_cap), 64'(vecs[v].exp_clk));
      check($sformatf("vec%0d_underrun", v), 64'(ur), 64'd0);
    end

    // reset in the middle of a run
    start(1'b0, 1'b0, 8'd1, 8'd15, 16'sd0);
    for (int c = 0; c < 5; c++) tick();
    SYSRST = 1'b1;
    tick();
    check("midreset_dsdout",   64'(DSDOUT), 64'd0);
    check("midreset_sdclkout", 64'(SDCLKOUT), 64'd0);
    check("midreset_ready",    64'(smp.sample_ready), 64'd1);
    check("midreset_underrun", 64'(underrun), 64'd0);
    check("midreset_state",    64'(dut.state_q), 64'(IDLE));
    SYSRST = 1'b0;

    // density: first order, x = +FS/2 over 64 bits
    start(1'b0, 1'b0, 8'd0, 8'd63, 16'sd16384);
    ones = 0;
    for (int c = 0; c < 128; c++) begin
      if (SDCLKOUT && DSDOUT) ones++;
      tick();
    end
    check("dens1_ones_in_47_49", 64'(ones >= 47 && ones <= 49), 64'd1);

    // density: second order, x = -FS/2 over 256 bits, i2 stays off the rails
    start(1'b0, 1'b1, 8'd0, 8'd255, -16'sd16384);
    ones = 0; i2max = 0;
    for (int c = 0; c < 512; c++) begin
      if (SDCLKOUT && DSDOUT) ones++;
      i2v = int'(dut.u_core.i2_q);
      if (i2v < 0) i2v = -i2v;
      if (i2v > i2max) i2max = i2v;
      tick();
    end
    check("dens2_ones_in_62_66", 64'(ones >= 62 && ones <= 66), 64'd1);
    check("dens2_i2_unsaturated", 64'(i2max < 2097151), 64'd1);

    // underrun with x reuse, then a bypass sample at the next boundary
    start(1'b0, 1'b0, 8'd0, 8'd3, 16'sd16384);
    smp.sample_valid = 1'b0;
    ur_seq = '0; dsd_seq = '0;
    for (int c = 0; c < 26; c++) begin
      ur_seq[c]  = underrun;
      dsd_seq[c] = DSDOUT;
      if (c == 16) check("bypass_ready", 64'(smp.sample_ready), 64'd1);
      if (c == 15) begin
        smp.sample_valid = 1'b1;
        smp.sample_data  = -16'sd16384;
      end
      if (c == 16) smp.sample_valid = 1'b0;
      tick();
    end
    check("underrun_pulses", 64'(ur_seq),  64'(26'b00000000100000000000000010));
    check("underrun_dsdout", 64'(dsd_seq), 64'(26'b11110011111100110011000000));

    // buffer full with a held sample, then en=0 mid-sample
    start(1'b0, 1'b0, 8'd0, 8'd3, 16'sd0);
    rdy_b = '0; dsd_b = '0; ur = 1'b0;
    for (int c = 0; c <= 20; c++) begin
      if (c < 20) begin
        rdy_b[c] = smp.sample_ready;
        dsd_b[c] = DSDOUT;
      end
      ur = ur | underrun;
      if (c == 0) smp.sample_data = 16'sd16384;
      if (c == 1) smp.sample_data = -16'sd16384;
      if (c == 9) smp.sample_valid = 1'b0;
      if (c == 17) begin
        smp.sample_valid = 1'b1;
        smp.sample_data  = 16'sd8192;
      end
      if (c == 18) smp.sample_valid = 1'b0;
      if (c == 20) en = 1'b0;
      tick();
    end
    check("buf_ready_seq",  64'(rdy_b), 64'(20'b10000000100000001100));
    check("buf_dsdout_seq", 64'(dsd_b), 64'(20'b11001100111100110011));
    check("buf_no_underrun", 64'(ur), 64'd0);
    check("dis_dsdout",   64'(DSDOUT), 64'd0);
    check("dis_sdclkout", 64'(SDCLKOUT), 64'd0);
    check("dis_state",    64'(dut.state_q), 64'(IDLE));
    check("dis_buf_kept", 64'(smp.sample_ready), 64'd0);
    tick(); tick(); tick();
    check("dis_buf_kept_later", 64'(smp.sample_ready), 64'd0);
    check("dis_dsdout_later",   64'(DSDOUT), 64'd0);

    // re-enable: run restarts from cleared integrators with the kept sample 8192
    en = 1'b1;
    tick();
    rdy0 = smp.sample_ready;
    dsd4 = '0;
    for (int c = 0; c < 4; c++) begin
      dsd4[3-c] = DSDOUT;
      tick();
    end
    check("restart_ready", 64'(rdy0), 64'd1);
    check("restart_dsdout", 64'(dsd4), 64'(4'b1100));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_modulator.md
# sd_modulator

Digital sigma-delta modulator: converts a stream of 16-bit signed samples into a 1-bit density-modulated bitstream, plus an optional companion bit clock. It is the transmit-side counterpart of the SDFM demodulator channel. Its outputs drive the SDFM `DSDIN`/`SDCLK` inputs directly, either for loopback self-test or as a stimulus/DAC source. Sample delivery uses a one-entry buffered valid/ready handshake.

## Interface
- `IN_W`, 16, sample width (signed two's complement).
- `DIV_W`, 8, width of `clkdiv`.
- `OSR_W`, 8, width of `osr`.
- `SYSCLK`  in  1  system clock; all logic on rising edge.
- `SYSRST`  in  1  reset, synchronous, active-high.
- `en`  in  1  run enable.
- `mode`  in  1  0 = NRZ data + bit clock, 1 = Manchester (no clock).
- `order`  in  1  0 = first-order loop, 1 = second-order loop.
- `clkdiv`  in  DIV_W  half-bit period = `clkdiv`+1 SYSCLK cycles.
- `osr`  in  OSR_W  bits per sample = `osr`+1.
- `sample_data`  in  IN_W  input sample.
- `sample_valid`  in  1  sample offered.
- `sample_ready`  out  1  buffer empty (= ~buf_full, combinational).
- `underrun`  out  1  one-cycle pulse: sample boundary with no new sample available.
- `DSDOUT`  out  1  modulated bitstream.
- `SDCLKOUT`  out  1  bit clock (mode 0), constant 0 in mode 1.

## Operation
- Reset: state IDLE; integrators, feedback, counters, buffer cleared; `DSDOUT`=0, `SDCLKOUT`=0, `underrun`=0, `sample_ready`=1.
- Buffer: loads on `sample_valid & sample_ready`. Valid data is held while ready is low.
- IDLE: outputs 0, integrators and feedback (fb) = 0. When `en`=1 and a sample is available (buffer full, or valid this cycle as bypass):
  - latch `mode`, `order`, `clkdiv`, `osr`;
  - move the sample to active register x;
  - perform the first modulator step;
  - go to RUN with cnt=0, phase=0, bcnt=0.
- Config inputs are ignored outside that cycle.
- RUN:
  - cnt counts 0..clkdiv; at cnt==clkdiv it wraps and toggles phase.
  - Bit tick = phase==1 & cnt==clkdiv.
  - At a bit tick, one modulator step runs and bcnt increments.
  - If bcnt==osr, the step uses the next sample and bcnt returns to 0.
- Next-sample selection at a boundary, in priority order:
  - buffer full → buffer contents;
  - else `sample_valid` → bypass (no underrun, ready stays 1);
  - else reuse x and pulse `underrun`.
- `en`=0 in RUN: next cycle IDLE, outputs 0, integrators cleared; buffer contents kept.
- Modulator step, FS = 2^15, with fb = previous ±FS (0 after clear):
  - order 0: i1 += x − fb; y = (i1 ≥ 0).
  - order 1: i1 += x − fb; i2 += i1 − fb; y = (i2 ≥ 0).
  - New fb = y ? +FS : −FS.
- Widths: i1 is 18-bit signed; i2 is 22-bit signed, saturating at ±(2^21−1). Sums are computed at full width before saturation.
- Outputs:
  - mode 0: `SDCLKOUT` = phase, `DSDOUT` = y.
  - mode 1: `DSDOUT` = phase ? y : ~y (0 = high→low, 1 = low→high).

## Timing
- All outputs are registered.
- Mode 0: `SDCLKOUT` falls and `DSDOUT` updates on the same SYSCLK edge. Data is stable for a full clkdiv+1 cycles before and after the `SDCLKOUT` rising edge.
- Bit period = 2·(clkdiv+1) cycles; sample period = (osr+1) bit periods.
- The first bit appears on the edge after the IDLE→RUN cycle.
- Buffer freed at a boundary: `sample_ready` rises the next cycle.
- `underrun` is high for exactly one cycle, aligned with the boundary step.
- `SYSRST` overrides `en` and all handshakes in the same cycle.

## Structure
- Package `sd_pkg`:
  - FS constant;
  - i1/i2 widths and saturation limits;
  - mode encodings (MODE_NRZ, MODE_MANCH);
  - state enum (IDLE, RUN).
- Sub-module `sd_mod_core`: integrators, feedback, saturation and y. Inputs are step, clear, order and x.
- The top level holds the buffer, divider, bit/sample counters, FSM and output encoding.

## Test plan
- Reset mid-RUN → next cycle `DSDOUT`=0, `SDCLKOUT`=0, `sample_ready`=1, `underrun`=0, FSM IDLE.
- Mode 0, order 0, clkdiv=1, osr=15, x=0 → `SDCLKOUT` period 4 cycles; `DSDOUT` = 1,0,1,0… with each bit changing on the `SDCLKOUT` falling edge.
- Order 0, x=16384, 64 bits → ones count 48±1. Order 1, x=−16384, 256 bits → ones count 64±2, and i2 never saturates.
- Mode 1, clkdiv=3, x=0 → `DSDOUT` = 0000 1111 1111 0000 repeating; `SDCLKOUT` constant 0.
- osr=3, one sample supplied, then none → `underrun` pulses 1 cycle at the bit-4 tick; x reused; then a bypass sample `sample_valid` at the next boundary with empty buffer → no underrun.
- Buffer full, `sample_valid` held with a new value → `sample_ready`=0 until the boundary, rises 1 cycle after, and the held sample is accepted; `en`=0 mid-sample → outputs 0 next cycle and the buffer is retained.
